// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx write port between two byte-stream requesters.
// The owner holds the channel until its last byte or MAX_BURST, and writes are paced against tx_ready.
module uart_tx_arbiter #(
   parameter int unsigned MAX_BURST     = 16,
   parameter int unsigned SETTLE_CYCLES = 1
) (
   input  logic       ACLK,
   input  logic       ARESETn,
   input  logic       req0_valid,
   input  logic [7:0] req0_data,
   input  logic       req0_last,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_data,
   input  logic       req1_last,
   output logic       req1_ready,
   input  logic       tx_ready,
   output logic       tx_data_reg_wr,
   output logic [7:0] tx_data,
   output logic [1:0] grant,
   output logic       busy
);

   localparam int unsigned DW = 8;
   localparam int unsigned BW = 8;
   localparam int unsigned SW = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEND   = 2'd1,
      SETTLE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [1:0]      r_grant;
   logic [1:0]      w_grant_nxt;
   logic            r_owner;
   logic            w_owner_nxt;
   logic            r_rr_ptr;
   logic            w_rr_nxt;
   logic [BW-1:0]   r_burst_cnt;
   logic [BW-1:0]   w_burst_nxt;
   logic [SW-1:0]   r_settle_cnt;
   logic [SW-1:0]   w_settle_nxt;
   logic            r_release;
   logic            w_release_nxt;

   logic            w_wr;
   logic [DW-1:0]   w_tx_data;
   logic [1:0]      w_ready;
   logic            w_own_valid;
   logic [DW-1:0]   w_own_data;
   logic            w_own_last;
   logic [BW-1:0]   w_burst_inc;

   assign w_own_valid = r_owner ? req1_valid : req0_valid;
   assign w_own_data  = r_owner ? req1_data  : req0_data;
   assign w_own_last  = r_owner ? req1_last  : req0_last;
   assign w_burst_inc = r_burst_cnt + BW'(1);

   // State register
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state, datapath updates and same-cycle write handshake
   always_comb begin
      w_state_nxt   = r_state;
      w_grant_nxt   = r_grant;
      w_owner_nxt   = r_owner;
      w_rr_nxt      = r_rr_ptr;
      w_burst_nxt   = r_burst_cnt;
      w_settle_nxt  = r_settle_cnt;
      w_release_nxt = r_release;
      w_wr          = 1'b0;
      w_tx_data     = '0;
      w_ready       = 2'b00;

      case (r_state)
         IDLE: begin
            if (req0_valid || req1_valid) begin
               w_owner_nxt   = (req0_valid && req1_valid) ? r_rr_ptr : req1_valid;
               w_grant_nxt   = w_owner_nxt ? 2'b10 : 2'b01;
               w_burst_nxt   = '0;
               w_release_nxt = 1'b0;
               w_state_nxt   = SEND;
            end
         end

         SEND: begin
            if (!w_own_valid) begin
               // Owner ran dry: give the channel up without a strobe
               w_grant_nxt = 2'b00;
               w_rr_nxt    = ~r_owner;
               w_state_nxt = IDLE;
            end else if (tx_ready) begin
               w_wr              = 1'b1;
               w_tx_data         = w_own_data;
               w_ready[r_owner]  = 1'b1;
               w_burst_nxt       = w_burst_inc;
               w_settle_nxt      = SW'(SETTLE_CYCLES);
               w_release_nxt     = w_own_last || (w_burst_inc == BW'(MAX_BURST));
               w_state_nxt       = SETTLE;
            end
         end

         SETTLE: begin
            // tx_ready is not trusted until uart_tx flags have caught up with the write
            w_settle_nxt = r_settle_cnt - SW'(1);
            if (r_settle_cnt <= SW'(1)) begin
               if (r_release) begin
                  w_grant_nxt = 2'b00;
                  w_rr_nxt    = ~r_owner;
                  w_state_nxt = IDLE;
               end else begin
                  w_state_nxt = SEND;
               end
            end
         end

         default: begin
            w_grant_nxt = 2'b00;
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Arbitration and pacing registers
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         r_grant      <= 2'b00;
         r_owner      <= 1'b0;
         r_rr_ptr     <= 1'b0;
         r_burst_cnt  <= '0;
         r_settle_cnt <= '0;
         r_release    <= 1'b0;
      end else begin
         r_grant      <= w_grant_nxt;
         r_owner      <= w_owner_nxt;
         r_rr_ptr     <= w_rr_nxt;
         r_burst_cnt  <= w_burst_nxt;
         r_settle_cnt <= w_settle_nxt;
         r_release    <= w_release_nxt;
      end
   end

   assign tx_data_reg_wr = w_wr;
   assign tx_data        = w_tx_data;
   assign req0_ready     = w_ready[0];
   assign req1_ready     = w_ready[1];
   assign grant          = r_grant;
   assign busy           = (r_state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: stimulus pushes expected {source,byte} pairs,
// a monitor pops and compares on every tx_data_reg_wr strobe.
module tb_uart_tx_arbiter;

   logic       ACLK;
   logic       ARESETn;
   logic       req0_valid;
   logic [7:0] req0_data;
   logic       req0_last;
   logic       req0_ready;
   logic       req1_valid;
   logic [7:0] req1_data;
   logic       req1_last;
   logic       req1_ready;
   logic       tx_ready;
   logic       tx_data_reg_wr;
   logic [7:0] tx_data;
   logic [1:0] grant;
   logic       busy;

   int n_checks = 0;
   int n_errors = 0;

   logic [8:0] q0[$];
   logic [8:0] q1[$];
   logic [8:0] exp_q[$];

   uart_tx_arbiter #(.MAX_BURST(16), .SETTLE_CYCLES(1)) dut (
      .ACLK           (ACLK),
      .ARESETn        (ARESETn),
      .req0_valid     (req0_valid),
      .req0_data      (req0_data),
      .req0_last      (req0_last),
      .req0_ready     (req0_ready),
      .req1_valid     (req1_valid),
      .req1_data      (req1_data),
      .req1_last      (req1_last),
      .req1_ready     (req1_ready),
      .tx_ready       (tx_ready),
      .tx_data_reg_wr (tx_data_reg_wr),
      .tx_data        (tx_data),
      .grant          (grant),
      .busy           (busy)
   );

   initial begin
      ACLK = 1'b0;
      forever #5 ACLK = ~ACLK;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_errors++;
         $display("FAIL %s: got %0h required %0h", nm, act, expv);
      end
   endtask

   task automatic wait_grant(input logic [1:0] g);
      int i;
      for (i = 0; i < 200; i++) begin
         @(negedge ACLK);
         if (grant == g) break;
      end
      chk("grant_wait", 32'(grant), 32'(g));
   endtask

   task automatic wait_idle();
      int i;
      for (i = 0; i < 600; i++) begin
         @(negedge ACLK);
         if (exp_q.size() == 0 && q0.size() == 0 && q1.size() == 0 &&
             !busy && !req0_valid && !req1_valid) break;
      end
      chk("drain_timeout", 32'(i < 600), 32'd1);
   endtask

   // Requester models: present queue heads, pop on accepted handshake
   initial begin : driver
      logic a0, a1;
      req0_valid = 1'b0; req0_data = 8'h00; req0_last = 1'b0;
      req1_valid = 1'b0; req1_data = 8'h00; req1_last = 1'b0;
      forever begin
         @(negedge ACLK);
         a0 = req0_valid & req0_ready;
         a1 = req1_valid & req1_ready;
         @(posedge ACLK);
         #1;
         if (a0 && q0.size() != 0) void'(q0.pop_front());
         if (a1 && q1.size() != 0) void'(q1.pop_front());
         if (q0.size() != 0) begin
            req0_valid = 1'b1;
            {req0_last, req0_data} = q0[0];
         end else begin
            req0_valid = 1'b0; req0_last = 1'b0; req0_data = 8'h00;
         end
         if (q1.size() != 0) begin
            req1_valid = 1'b1;
            {req1_last, req1_data} = q1[0];
         end else begin
            req1_valid = 1'b0; req1_last = 1'b0; req1_data = 8'h00;
         end
      end
   end

   // Monitor: compares every strobe against the scoreboard
   initial begin : monitor
      int cyc;
      int last_wr;
      logic [8:0] e;
      cyc = 0;
      last_wr = -100;
      forever begin
         @(negedge ACLK);
         cyc++;
         if (ARESETn && tx_data_reg_wr) begin
            chk("strobe_spacing", 32'((cyc - last_wr) >= 2), 32'd1);
            last_wr = cyc;
            chk("ready_matches_grant", 32'({req1_ready, req0_ready}), 32'(grant));
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_strobe: got %0h required no strobe", tx_data);
            end else begin
               e = exp_q.pop_front();
               chk("tx_byte", 32'({req1_ready, tx_data}), 32'(e));
            end
         end else if (ARESETn) begin
            chk("ready_without_strobe", 32'({req1_ready, req0_ready}), 32'd0);
         end
      end
   end

   initial begin : main
      int found;
      tx_ready = 1'b1;
      ARESETn  = 1'b0;
      repeat (3) @(negedge ACLK);
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_wr", 32'(tx_data_reg_wr), 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'd0);
      chk("rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
      ARESETn = 1'b1;
      @(negedge ACLK);

      // Both valid from reset: rr_ptr=0 gives req0 first
      for (int i = 0; i < 3; i++) begin
         q0.push_back({1'(i == 2), 8'(8'h10 + i)});
         q1.push_back({1'(i == 2), 8'(8'h20 + i)});
      end
      for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, 8'(8'h10 + i)});
      for (int i = 0; i < 3; i++) exp_q.push_back({1'b1, 8'(8'h20 + i)});
      wait_idle();

      // Single byte timing: arbitrate, strobe, settle, release
      q0.push_back({1'b1, 8'h41});
      exp_q.push_back({1'b0, 8'h41});
      @(negedge ACLK);
      chk("t1_arb_grant", 32'(grant), 32'd0);
      chk("t1_arb_wr", 32'(tx_data_reg_wr), 32'd0);
      @(negedge ACLK);
      chk("t1_send_grant", 32'(grant), 32'h1);
      chk("t1_send_wr", 32'(tx_data_reg_wr), 32'd1);
      chk("t1_send_data", 32'(tx_data), 32'h41);
      chk("t1_send_ready", 32'(req0_ready), 32'd1);
      @(negedge ACLK);
      chk("t1_settle_wr", 32'(tx_data_reg_wr), 32'd0);
      chk("t1_settle_grant", 32'(grant), 32'h1);
      @(negedge ACLK);
      chk("t1_release_grant", 32'(grant), 32'd0);
      chk("t1_release_busy", 32'(busy), 32'd0);
      wait_idle();

      // Both valid again after rr_ptr toggled: req1 first
      for (int i = 0; i < 3; i++) begin
         q0.push_back({1'(i == 2), 8'(8'h10 + i)});
         q1.push_back({1'(i == 2), 8'(8'h20 + i)});
      end
      for (int i = 0; i < 3; i++) exp_q.push_back({1'b1, 8'(8'h20 + i)});
      for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, 8'(8'h10 + i)});
      wait_idle();

      // Burst limit: req1 forced off after 16 bytes, req0 served, req1 resumes
      for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, 8'(8'h60 + i)});
      exp_q.push_back({1'b0, 8'hA0});
      exp_q.push_back({1'b0, 8'hA1});
      for (int i = 16; i < 20; i++) exp_q.push_back({1'b1, 8'(8'h60 + i)});
      for (int i = 0; i < 20; i++) q1.push_back({1'b0, 8'(8'h60 + i)});
      wait_grant(2'b10);
      q0.push_back({1'b0, 8'hA0});
      q0.push_back({1'b1, 8'hA1});
      wait_idle();

      // tx_ready stall: grant held, no strobe, strobe in the cycle tx_ready rises
      tx_ready = 1'b0;
      q0.push_back({1'b0, 8'h55});
      q0.push_back({1'b1, 8'h56});
      exp_q.push_back({1'b0, 8'h55});
      exp_q.push_back({1'b0, 8'h56});
      wait_grant(2'b01);
      for (int i = 0; i < 10; i++) begin
         @(negedge ACLK);
         chk("stall_no_strobe", 32'(tx_data_reg_wr), 32'd0);
      end
      chk("stall_grant_held", 32'(grant), 32'h1);
      @(posedge ACLK);
      #1 tx_ready = 1'b1;
      @(negedge ACLK);
      chk("ready_same_cycle_wr", 32'(tx_data_reg_wr), 32'd1);
      chk("ready_same_cycle_data", 32'(tx_data), 32'h55);
      @(negedge ACLK);
      chk("settle_ignores_ready", 32'(tx_data_reg_wr), 32'd0);
      wait_idle();

      // Owner runs dry mid-packet: released without strobe, other side granted
      exp_q.push_back({1'b0, 8'h70});
      exp_q.push_back({1'b0, 8'h71});
      exp_q.push_back({1'b1, 8'h80});
      exp_q.push_back({1'b1, 8'h81});
      q0.push_back({1'b0, 8'h70});
      q0.push_back({1'b0, 8'h71});
      wait_grant(2'b01);
      q1.push_back({1'b0, 8'h80});
      q1.push_back({1'b1, 8'h81});
      wait_grant(2'b00);
      wait_grant(2'b10);
      wait_idle();

      // Leave rr_ptr=1, then reset during SETTLE of a req1 burst
      q0.push_back({1'b1, 8'h33});
      exp_q.push_back({1'b0, 8'h33});
      wait_idle();
      exp_q.push_back({1'b1, 8'h90});
      for (int i = 0; i < 4; i++) q1.push_back({1'(i == 3), 8'(8'h90 + i)});
      found = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge ACLK);
         if (tx_data_reg_wr) begin
            found = 1;
            break;
         end
      end
      chk("reset_wait_strobe", 32'(found), 32'd1);
      @(negedge ACLK);
      chk("pre_reset_busy", 32'(busy), 32'd1);
      #2 ARESETn = 1'b0;
      #1;
      chk("async_rst_grant", 32'(grant), 32'd0);
      chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_wr", 32'(tx_data_reg_wr), 32'd0);
      chk("async_rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
      q1.delete();
      repeat (2) @(negedge ACLK);
      ARESETn = 1'b1;
      @(negedge ACLK);

      // Fresh packets after reset: rr_ptr back to 0, so req0 first
      q0.push_back({1'b1, 8'hA5});
      q1.push_back({1'b1, 8'hB5});
      exp_q.push_back({1'b0, 8'hA5});
      exp_q.push_back({1'b1, 8'hB5});
      wait_idle();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
